// File: rtl/life_pkg.sv
// life_pkg: shared constants, FSM state type and column-order helper for the Life engine
//   GRID_ROWS/GRID_COLS: grid shape (RAM words / bits per word)
//   ADDR_W: RAM address width; state_t: engine FSM states
//   col_bit(): bit index of a column (bit COLS-1 is column 0)
package life_pkg;
   localparam int GRID_ROWS = 30;
   localparam int GRID_COLS = 40;
   localparam int ADDR_W = 5;
   typedef enum logic [2:0] {IDLE, PRIME_A, PRIME_C, RD_A, RD_C, WR, DONE} state_t;
   function automatic int col_bit(input int col);
      return GRID_COLS - 1 - col;
   endfunction
endpackage

// File: rtl/life_row_calc.sv
// life_row_calc: combinational B3/S23 next state for one row from its three-row window
//   prev, cur, nxt: rows above, at and below the target (MSB = column 0)
//   next_row: next generation of cur
module life_row_calc
   import life_pkg::*;
#(
   parameter int COLS = GRID_COLS
) (
   input  logic [COLS-1:0] prev,
   input  logic [COLS-1:0] cur,
   input  logic [COLS-1:0] nxt,
   output logic [COLS-1:0] next_row
);
   // one dead cell padded on each side so edge columns see no wrap-around
   logic [COLS+1:0] p, c, n;
   assign p = {1'b0, prev, 1'b0};
   assign c = {1'b0, cur, 1'b0};
   assign n = {1'b0, nxt, 1'b0};
   for (genvar i = 0; i < COLS; i++) begin : g_cell
      logic [3:0] cnt;
      assign cnt = 4'(p[i]) + 4'(p[i+1]) + 4'(p[i+2]) + 4'(c[i]) + 4'(c[i+2])
                 + 4'(n[i]) + 4'(n[i+1]) + 4'(n[i+2]);
      assign next_row[i] = (cnt == 4'd3) | (cur[i] & (cnt == 4'd2));
   end
endmodule

// File: rtl/life_gen_engine.sv
// life_gen_engine: one in-place Game of Life generation over a RAM-held grid
//   clk, reset (async, active high); start: request a generation (IDLE only)
//   busy: not idle; done: end-of-generation pulse; changed: some row differed
//   gen_count: completed generations
//   ram_addr, ram_wdata, ram_wren: RAM request; ram_rdata: read data, one cycle latency
module life_gen_engine
   import life_pkg::*;
#(
   parameter int ROWS  = GRID_ROWS,
   parameter int COLS  = GRID_COLS,
   parameter int GEN_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              changed,
   output logic [GEN_W-1:0]  gen_count,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [COLS-1:0]   ram_wdata,
   output logic              ram_wren,
   input  logic [COLS-1:0]   ram_rdata
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ROWS - 1);
   state_t state;
   logic [COLS-1:0] prev, cur, nxt, calc;
   logic [ADDR_W-1:0] r, r_inc;
   life_row_calc #(.COLS(COLS)) u_calc (.prev(prev), .cur(cur), .nxt(nxt), .next_row(calc));
   assign r_inc = r + 1'b1;
   assign busy = state != IDLE;
   assign done = state == DONE;
   always_comb begin
      ram_wren = state == WR;
      ram_addr = state == RD_A ? r_inc : state == WR ? r : '0;
      ram_wdata = ram_wren ? calc : '0;
   end
   // the old copy of row r is still in cur when WR overwrites it, so in-place is safe
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         changed <= 1'b0;
         gen_count <= '0;
         prev <= '0;
         cur <= '0;
         nxt <= '0;
         r <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= PRIME_A;
               changed <= 1'b0;
            end
            PRIME_A: state <= PRIME_C;
            PRIME_C: begin
               cur <= ram_rdata;
               prev <= '0;
               r <= '0;
               state <= RD_A;
            end
            RD_A: state <= RD_C;
            RD_C: begin
               nxt <= ram_rdata;
               state <= WR;
            end
            WR: begin
               prev <= cur;
               cur <= nxt;
               r <= r_inc;
               if (calc != cur) changed <= 1'b1;
               // the last row has no row below it: feed zeros instead of a read
               if (r_inc == LAST) nxt <= '0;
               else state <= r == LAST ? DONE : RD_A;
            end
            DONE: begin
               gen_count <= gen_count + 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_life_gen_engine.sv
// tb_life_gen_engine: directed checks of the row calculator and the in-place generation engine
module tb_life_gen_engine;
   import life_pkg::*;
   localparam int R = 30;
   localparam int C = 40;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic busy, done, changed, ram_wren;
   logic [15:0] gen_count;
   logic [4:0] ram_addr;
   logic [C-1:0] ram_wdata, ram_rdata;
   always #5 clk = ~clk;
   life_gen_engine dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .changed(changed),
      .gen_count(gen_count), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
      .ram_rdata(ram_rdata)
   );
   logic [C-1:0] mem [32];
   logic ld_en = 1'b0;
   logic [4:0] ld_addr = '0;
   logic [C-1:0] ld_data = '0;
   logic mon_clr = 1'b0;
   int wr_cnt = 0, order_err = 0, addr_bad = 0;
   logic [4:0] exp_wa = '0;
   always @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      else if (ram_wren) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
      if (mon_clr) begin
         wr_cnt <= 0;
         order_err <= 0;
         exp_wa <= '0;
      end else if (ram_wren) begin
         wr_cnt <= wr_cnt + 1;
         exp_wa <= exp_wa + 1'b1;
         if (ram_addr != exp_wa) order_err <= order_err + 1;
      end
      if (ram_addr > 5'd29) addr_bad <= addr_bad + 1;
   end
   logic [C-1:0] tp, tc, tn, tq;
   life_row_calc #(.COLS(C)) u_rc (.prev(tp), .cur(tc), .nxt(tn), .next_row(tq));
   typedef struct {
      string name;
      logic [C-1:0] p, c, n, q;
   } vec_t;
   vec_t tv [9];
   int checks = 0, errors = 0;
   logic [C-1:0] g_old [R];
   logic [C-1:0] g_exp [R];
   logic [C-1:0] blink [R];
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask
   function automatic logic [C-1:0] cols(input int lo, input int hi);
      logic [C-1:0] m = '0;
      for (int k = lo; k <= hi; k++) m[col_bit(k)] = 1'b1;
      return m;
   endfunction
   task automatic clear_grids();
      for (int k = 0; k < R; k++) begin
         g_old[k] = '0;
         g_exp[k] = '0;
      end
   endtask
   task automatic load_grid();
      for (int k = 0; k < R; k++) begin
         @(negedge clk);
         ld_en = 1'b1;
         ld_addr = 5'(k);
         ld_data = g_old[k];
      end
      @(negedge clk);
      ld_en = 1'b0;
   endtask
   task automatic model_step();
      for (int rr = 0; rr < R; rr++)
         for (int cc = 0; cc < C; cc++) begin
            int nb = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if ((dr != 0 || dc != 0) && rr + dr >= 0 && rr + dr < R && cc + dc >= 0 && cc + dc < C)
                     nb += int'(g_old[rr+dr][C-1-(cc+dc)]);
            g_exp[rr][C-1-cc] = (nb == 3) || (g_old[rr][C-1-cc] && nb == 2);
         end
   endtask
   task automatic check_grid(input string tag);
      for (int k = 0; k < R; k++) check($sformatf("%s row%0d", tag, k), 64'(mem[k]), 64'(g_exp[k]));
   endtask
   task automatic run_gen(input int restart_at);
      int n = 0;
      @(negedge clk);
      mon_clr = 1'b1;
      @(negedge clk);
      mon_clr = 1'b0;
      start = 1'b1;
      while (n < 200) begin
         @(negedge clk);
         n++;
         start = n == restart_at;
         if (n == 1) check("busy rise", 64'(busy), 64'd1);
         if (done) break;
      end
      start = 1'b0;
      check("done latency", 64'(n), 64'd91);
      @(negedge clk);
      check("done/busy fall", 64'({busy, done}), 64'd0);
      check("idle bus", 64'({ram_wren, ram_addr, ram_wdata}), 64'd0);
      check("write count", 64'(wr_cnt), 64'(R));
      check("write order", 64'(order_err), 64'd0);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n;
      tv[0] = '{"empty", '0, '0, '0, '0};
      tv[1] = '{"blinker row", '0, cols(18, 20), '0, cols(19, 19)};
      tv[2] = '{"birth below", '0, '0, cols(18, 20), cols(19, 19)};
      tv[3] = '{"left edge", cols(0, 0), cols(0, 0), cols(0, 0), cols(0, 1)};
      tv[4] = '{"right edge", cols(39, 39), cols(39, 39), cols(39, 39), cols(38, 39)};
      tv[5] = '{"crowded", '1, '1, '1, '0};
      tv[6] = '{"block", '0, cols(10, 11), cols(10, 11), cols(10, 11)};
      tv[7] = '{"mixed birth", cols(4, 4), cols(6, 6), cols(5, 5), cols(5, 5)};
      tv[8] = '{"overcrowd", cols(9, 11), cols(10, 10), cols(10, 10), '0};
      for (int k = 0; k < 9; k++) begin
         tp = tv[k].p;
         tc = tv[k].c;
         tn = tv[k].n;
         #1;
         check({"calc ", tv[k].name}, 64'(tq), 64'(tv[k].q));
      end
      repeat (3) @(negedge clk);
      check("reset busy/done/changed", 64'({busy, done, changed}), 64'd0);
      check("reset gen_count", 64'(gen_count), 64'd0);
      check("reset bus", 64'({ram_wren, ram_addr, ram_wdata}), 64'd0);
      check("reset no writes", 64'(wr_cnt), 64'd0);
      ld_en = 1'b1;
      ld_addr = 5'd30;
      ld_data = 40'hA5_5A5A_A5A5;
      @(negedge clk);
      ld_addr = 5'd31;
      ld_data = 40'h5A_A5A5_5A5A;
      @(negedge clk);
      ld_en = 1'b0;
      reset = 1'b0;
      // blinker, with an ignored start pulse at cycle 30
      clear_grids();
      g_old[14] = cols(18, 20);
      for (int k = 0; k < R; k++) blink[k] = g_old[k];
      load_grid();
      run_gen(30);
      g_exp[13] = cols(19, 19);
      g_exp[14] = cols(19, 19);
      g_exp[15] = cols(19, 19);
      check_grid("blinker");
      check("blinker changed", 64'(changed), 64'd1);
      check("blinker gen_count", 64'(gen_count), 64'd1);
      // block still life
      clear_grids();
      g_old[5] = cols(10, 11);
      g_old[6] = cols(10, 11);
      g_exp[5] = cols(10, 11);
      g_exp[6] = cols(10, 11);
      load_grid();
      run_gen(0);
      check_grid("block");
      check("block changed", 64'(changed), 64'd0);
      check("block gen_count", 64'(gen_count), 64'd2);
      // top edge, no wrap
      clear_grids();
      g_old[0] = cols(0, 2);
      g_exp[0] = cols(1, 1);
      g_exp[1] = cols(1, 1);
      load_grid();
      run_gen(0);
      check_grid("edge");
      check("edge changed", 64'(changed), 64'd1);
      check("edge gen_count", 64'(gen_count), 64'd3);
      // start held high: a second generation follows directly after done
      for (int k = 0; k < R; k++) g_old[k] = blink[k];
      load_grid();
      @(negedge clk);
      mon_clr = 1'b1;
      @(negedge clk);
      mon_clr = 1'b0;
      start = 1'b1;
      n = 0;
      while (n < 200 && !done) begin
         @(negedge clk);
         n++;
      end
      check("held first latency", 64'(n), 64'd91);
      @(negedge clk);
      check("held idle gap", 64'(busy), 64'd0);
      @(negedge clk);
      check("held restart", 64'(busy), 64'd1);
      start = 1'b0;
      n = 0;
      while (n < 200 && !done) begin
         @(negedge clk);
         n++;
      end
      check("held second latency", 64'(n), 64'd90);
      @(negedge clk);
      for (int k = 0; k < R; k++) g_exp[k] = blink[k];
      check_grid("blinker x2");
      check("held gen_count", 64'(gen_count), 64'd5);
      check("held write count", 64'(wr_cnt), 64'd60);
      // abort mid-generation, then rerun against the model
      for (int k = 0; k < R; k++) g_old[k] = C'({$urandom(), $urandom()});
      load_grid();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      reset = 1'b1;
      #1;
      check("abort busy/wren", 64'({busy, ram_wren}), 64'd0);
      check("abort gen_count", 64'(gen_count), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < R; k++) g_old[k] = mem[k];
      model_step();
      run_gen(0);
      check_grid("abort rerun");
      check("abort rerun gen_count", 64'(gen_count), 64'd1);
      for (int k = 0; k < R; k++) g_old[k] = mem[k];
      model_step();
      run_gen(0);
      check_grid("model gen2");
      check("row 30 untouched", 64'(mem[30]), 64'h00A5_5A5A_A5A5);
      check("row 31 untouched", 64'(mem[31]), 64'h005A_A5A5_5A5A);
      check("addr range", 64'(addr_bad), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/life_gen_engine.md
# life_gen_engine

Computes one Game of Life generation (rule B3/S23) in place over the 30×40 cell grid held in the 40-bit × 32-word grid RAM. It sits upstream of the display/plot controller. On `start` it streams rows through a three-row window and writes each next-generation row back to the same RAM. The top level multiplexes RAM ownership to this block while `busy` is high. Rows 30–31 are never accessed.

## Interface
Parameters:
- `ROWS`, default 30: grid rows; RAM words 0..ROWS-1.
- `COLS`, default 40: cells per row; RAM word width.
- `GEN_W`, default 16: generation counter width.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request one generation; sampled only in IDLE.
- `busy`, output, 1: high in every non-IDLE state.
- `done`, output, 1: one-cycle pulse at the end of a generation.
- `changed`, output, 1: at least one row differed from its old value; valid from `done` until the next `start`.
- `gen_count`, output, GEN_W: completed generations; wraps at 2^GEN_W.
- `ram_addr`, output, 5: RAM address.
- `ram_wdata`, output, COLS: write data.
- `ram_wren`, output, 1: write enable.
- `ram_rdata`, input, COLS: RAM read data, valid one clock after the address is presented.

## Operation
- Bit COLS-1 (MSB) is column 0. Cells outside rows 0..ROWS-1 or columns 0..COLS-1 are dead; there is no wrap-around.
- Registers: `prev`, `cur`, `nxt` (COLS bits each), row index `r` (5 bits).
- States:
  - IDLE: `start` → PRIME_A.
  - PRIME_A: `ram_addr`=0 → PRIME_C.
  - PRIME_C: `cur`←`ram_rdata`, `prev`←0, `r`←0 → RD_A.
  - RD_A: `ram_addr`=`r`+1 → RD_C.
  - RD_C: `nxt`←`ram_rdata` → WR.
  - WR: `ram_addr`=`r`, `ram_wren`=1, `ram_wdata`=calc(`prev`,`cur`,`nxt`).
    - Also: `prev`←`cur`, `cur`←`nxt`, `r`←`r`+1.
    - If `r`+1 = ROWS-1: `nxt`←0, stay in WR.
    - If `r` = ROWS-1: → DONE.
    - Otherwise → RD_A.
  - DONE: `done`=1, `gen_count`+=1 → IDLE.
- In-place writing is safe because the old row `r` is still held in the window when it is overwritten.
- `changed` is cleared on leaving IDLE. It is set in WR when `ram_wdata` ≠ `cur`.
- calc, per cell: count the 8 neighbours (4-bit sum). Next = (count==3) | (alive & count==2).
- `start` while busy is ignored. `start` held high in IDLE after DONE begins a new generation.

## Timing
- Reset values: state IDLE; `busy`, `done`, `changed`, `ram_wren` = 0; `ram_addr` = 0; `ram_wdata` = 0; `gen_count` = 0.
- `ram_addr`, `ram_wren`, `ram_wdata` are decoded from the state and registers. They are 0 in IDLE and DONE.
- `start` sampled high at edge k: `busy` rises after edge k.
- Latency: 2 (prime) + 29×3 (rows 0–28) + 1 (row 29) + 1 (DONE) = 91 busy cycles. `done` is high in the 91st cycle. `busy` falls on the same edge as `done`.
- Exactly ROWS writes occur, in ascending address order 0..29. Each write follows the read of the next row by 2 cycles.
- Reset mid-operation aborts immediately. Rows already written keep their new values. `gen_count` returns to 0.

## Structure
- Package `life_pkg`: ROWS, COLS, address width 5, the state enumeration (IDLE, PRIME_A, PRIME_C, RD_A, RD_C, WR, DONE), and the MSB-is-column-0 convention.
- Sub-module `life_row_calc`: combinational; inputs `prev`, `cur`, `nxt` (COLS bits each), output the next row. Reused by the bench reference model.
- The engine file holds the FSM, window registers, and counters. The RAM instance is external.

## Test plan
- Reset: assert `reset` for 3 cycles → all outputs 0, `gen_count`=0, no RAM writes.
- Blinker: row 14 has columns 18–20 set, all other rows 0. Pulse `start` → `done` on cycle 91. Rows 13, 14, 15 then have only column 19 set. `changed`=1, `gen_count`=1.
- Block still life: rows 5–6 have columns 10–11 set → grid unchanged after `done`, `changed`=0.
- Edge, no wrap: row 0 has columns 0–2 set → result is column 1 in rows 0 and 1 only. Row 29 and column 39 stay 0.
- Bus protocol: `start` pulsed again at cycle 30 is ignored. Exactly 30 `ram_wren` pulses, addresses 0..29 ascending. `ram_addr` never exceeds 29.
- Abort: assert `reset` at cycle 40 → `busy`/`ram_wren` drop immediately. Re-run from IDLE → result matches the `life_row_calc` model applied to the RAM contents at restart.
